// File: rtl/uc_loader.sv
// uc_loader: assembles a framed little-endian byte stream into
// microcode words, writes them to the control store, checks the sum.
module uc_loader #(
    parameter int addr_width = 8,
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_adr,
    output logic [data_width-1:0] mem_din,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [addr_width:0]   word_count
);

    localparam int BPW = data_width / 8;
    localparam logic [7:0] LAST = 8'(BPW - 1);
    localparam logic [16:0] CAP = 17'd1 << addr_width;

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERR
    } state_t;

    state_t                state;
    logic [15:0]           len;
    logic [7:0]            idx;
    logic [7:0]            csum;
    logic [data_width-1:0] asm_word;
    logic [data_width-1:0] word_nxt;
    logic [15:0]           len_full;
    logic [15:0]           wc_next;
    logic                  xfer;

    // Outputs decoded straight from the state register (glitch-free)
    assign byte_ready = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == DATA) || (state == CSUM);
    assign busy = (state != IDLE) && (state != DONE) && (state != ERR);
    assign mem_we = (state == WRITE);

    assign xfer = byte_valid & byte_ready;
    assign len_full = {byte_in, len[7:0]};
    assign wc_next = 16'(word_count) + 16'd1;

    // Drop the incoming byte into its lane of the word being built
    always_comb begin
        word_nxt = asm_word;
        for (int i = 0; i < BPW; i++) begin
            if (idx == 8'(i)) word_nxt[i*8 +: 8] = byte_in;
        end
    end

    // Frame parser, word writer and checksum FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len        <= '0;
            idx        <= '0;
            csum       <= '0;
            asm_word   <= '0;
            mem_adr    <= '0;
            mem_din    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LEN_LO;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                        mem_adr    <= '0;
                        csum       <= '0;
                        idx        <= '0;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= byte_in;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= byte_in;
                        idx       <= '0;
                        if ({1'b0, len_full} > CAP) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else if (len_full == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        asm_word <= word_nxt;
                        csum     <= csum + byte_in;
                        if (idx == LAST) begin
                            idx     <= '0;
                            mem_din <= word_nxt;
                            state   <= WRITE;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                end
                WRITE: begin
                    mem_adr    <= mem_adr + addr_width'(1);
                    word_count <= word_count + (addr_width + 1)'(1);
                    state      <= (wc_next == len) ? CSUM : DATA;
                end
                CSUM: begin
                    if (xfer) begin
                        if (byte_in == csum) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uc_loader.sv
// tb_uc_loader: directed scenario tasks for the microcode loader,
// writes captured by a monitor and compared against hand-made values.
module tb_uc_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_adr;
    logic [15:0] mem_din;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  word_count;

    int pass_cnt = 0;
    int total = 0;

    logic [7:0]  wa[$];
    logic [15:0] wd[$];
    int          rdy_viol = 0;

    uc_loader #(.addr_width(8), .data_width(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_adr    (mem_adr),
        .mem_din    (mem_din),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Capture every write strobe seen at a clock edge
    always @(posedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_adr);
            wd.push_back(mem_din);
            if (byte_ready) rdy_viol++;
        end
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        rdy_viol = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Present one byte and hold it until the loader takes it
    task automatic send(input logic [7:0] b);
        bit ok = 0;
        byte_in = b;
        byte_valid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk);
                #1 ok = 1;
            end
        end
        if (!ok) begin
            total++;
            $display("FAIL send_timeout byte=%h", b);
        end
    endtask

    task automatic idle_bus(input int n);
        byte_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string nm, input int n);
        total++;
        if (wa.size() !== n || rdy_viol != 0)
            $display("FAIL %s_count got %0d writes viol %0d exp %0d",
                     nm, wa.size(), rdy_viol, n);
        else pass_cnt++;
        if (n == 2 && wa.size() == 2) begin
            total++;
            if ({wa[0], wd[0], wa[1], wd[1]} !==
                {8'd0, 16'h1234, 8'd1, 16'hABCD})
                $display("FAIL %s_data got %h@%h %h@%h exp 1234@00 abcd@01",
                         nm, wd[0], wa[0], wd[1], wa[1]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({byte_ready, mem_we, mem_adr, mem_din, busy, done, err,
             word_count} !== '0)
            $display("FAIL reset got rdy%b we%b adr%h din%h b%b d%b e%b wc%0d exp all 0",
                     byte_ready, mem_we, mem_adr, mem_din, busy, done,
                     err, word_count);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_good_load();
        clear_log();
        pulse_start();
        total++;
        if ({busy, done, err, byte_ready} !== 4'b1001)
            $display("FAIL good_start got b%b d%b e%b r%b exp 1 0 0 1",
                     busy, done, err, byte_ready);
        else pass_cnt++;
        send(8'h02);
        send(8'h00);
        send(8'h34);
        send(8'h12);
        total++;
        if ({mem_we, byte_ready, mem_adr, mem_din} !== {2'b10, 8'h00, 16'h1234})
            $display("FAIL good_latency got we%b r%b %h@%h exp we1 r0 1234@00",
                     mem_we, byte_ready, mem_din, mem_adr);
        else pass_cnt++;
        send(8'hCD);
        send(8'hAB);
        send(8'hBE);
        byte_valid = 1'b0;
        total++;
        if ({busy, done, err, word_count} !== {3'b010, 9'd2})
            $display("FAIL good_status got b%b d%b e%b wc%0d exp 0 1 0 2",
                     busy, done, err, word_count);
        else pass_cnt++;
        idle_bus(3);
        total++;
        if ({done, err, mem_din, mem_adr} !== {2'b10, 16'hABCD, 8'd2})
            $display("FAIL good_hold got d%b e%b din%h adr%h exp 1 0 abcd 02",
                     done, err, mem_din, mem_adr);
        else pass_cnt++;
        check_writes("good", 2);
    endtask

    task automatic test_bad_csum();
        clear_log();
        pulse_start();
        total++;
        if ({done, err, word_count} !== 11'd0)
            $display("FAIL bad_clear got d%b e%b wc%0d exp 0 0 0",
                     done, err, word_count);
        else pass_cnt++;
        send(8'h02);
        send(8'h00);
        send(8'h34);
        send(8'h12);
        send(8'hCD);
        send(8'hAB);
        send(8'hBF);
        byte_valid = 1'b0;
        total++;
        if ({busy, done, err, word_count} !== {3'b001, 9'd2})
            $display("FAIL bad_status got b%b d%b e%b wc%0d exp 0 0 1 2",
                     busy, done, err, word_count);
        else pass_cnt++;
        idle_bus(2);
        check_writes("bad", 2);
    endtask

    task automatic test_zero_and_overflow();
        clear_log();
        pulse_start();
        send(8'h00);
        send(8'h00);
        send(8'h00);
        byte_valid = 1'b0;
        total++;
        if ({busy, done, err, word_count} !== {3'b010, 9'd0})
            $display("FAIL zero_status got b%b d%b e%b wc%0d exp 0 1 0 0",
                     busy, done, err, word_count);
        else pass_cnt++;
        idle_bus(2);
        check_writes("zero", 0);
        pulse_start();
        send(8'h01);
        send(8'h01);
        byte_valid = 1'b0;
        total++;
        if ({busy, done, err, byte_ready, mem_we} !== 5'b00100)
            $display("FAIL ovf_status got b%b d%b e%b r%b we%b exp 0 0 1 0 0",
                     busy, done, err, byte_ready, mem_we);
        else pass_cnt++;
        idle_bus(3);
        total++;
        if ({err, byte_ready, word_count} !== {2'b10, 9'd0})
            $display("FAIL ovf_idle got e%b r%b wc%0d exp 1 0 0",
                     err, byte_ready, word_count);
        else pass_cnt++;
        check_writes("ovf", 0);
    endtask

    task automatic test_backpressure();
        logic [7:0] fr [7];
        fr = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hBE};
        clear_log();
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            idle_bus($urandom_range(0, 3));
            if (i == 3 || i == 5) pulse_start();
            send(fr[i]);
        end
        byte_valid = 1'b0;
        total++;
        if ({busy, done, err, word_count} !== {3'b010, 9'd2})
            $display("FAIL bp_status got b%b d%b e%b wc%0d exp 0 1 0 2",
                     busy, done, err, word_count);
        else pass_cnt++;
        idle_bus(2);
        check_writes("bp", 2);
    endtask

    task automatic test_reset_midload();
        clear_log();
        pulse_start();
        send(8'h02);
        send(8'h00);
        send(8'h34);
        byte_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({byte_ready, mem_we, mem_adr, mem_din, busy, done, err,
             word_count} !== '0)
            $display("FAIL mid_reset got r%b we%b adr%h din%h b%b d%b e%b wc%0d exp all 0",
                     byte_ready, mem_we, mem_adr, mem_din, busy, done,
                     err, word_count);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        idle_bus(2);
        check_writes("mid_rst", 0);
        test_good_load();
    endtask

    task automatic test_full_store();
        bit ok = 1;
        clear_log();
        pulse_start();
        send(8'h00);
        send(8'h01);
        for (int i = 0; i < 256; i++) begin
            send(8'(i));
            send(8'h00);
        end
        send(8'h80);
        byte_valid = 1'b0;
        total++;
        if ({busy, done, err, word_count} !== {3'b010, 9'd256})
            $display("FAIL full_status got b%b d%b e%b wc%0d exp 0 1 0 256",
                     busy, done, err, word_count);
        else pass_cnt++;
        idle_bus(2);
        total++;
        if (wa.size() != 256) ok = 0;
        for (int i = 0; i < wa.size() && ok; i++)
            if (wa[i] !== 8'(i) || wd[i] !== 16'(i)) ok = 0;
        if (!ok || rdy_viol != 0)
            $display("FAIL full_writes got n%0d viol%0d exp 256 data=addr",
                     wa.size(), rdy_viol);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_csum();
        test_zero_and_overflow();
        test_backpressure();
        test_reset_midload();
        test_full_store();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/uc_loader.md
Name: uc_loader

Overview:
Writer-side companion to the microcode store. It accepts a framed byte stream from a host or boot source over a valid/ready handshake and assembles little-endian microcode words. It writes each word into the microcode RAM at incrementing addresses starting at 0, then verifies a trailing checksum. It sits between the boot/debug byte channel and the write port of the microcode memory, and loads the control store before the CPU is released from hold.

Parameters:
addr_width, 8, microcode address width; the store holds 1<<addr_width words
data_width, 16, microcode word width; must be a multiple of 8 (BPW = data_width/8 bytes per word)

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a load when idle
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts byte this cycle (transfer = byte_valid & byte_ready)
mem_we  output  1  one-cycle write strobe to microcode RAM
mem_adr  output  addr_width  write address
mem_din  output  data_width  write data
busy  output  1  high while a load is in progress
done  output  1  sticky: load completed with a good checksum
err  output  1  sticky: load failed (length overflow or bad checksum)
word_count  output  addr_width+1  words written in the current or last load

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, including byte_ready, mem_we, mem_adr, mem_din, busy, done, err and word_count. Internal length, byte index and checksum are cleared.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N words of BPW bytes each (LSB first), then CSUM.
- CSUM is the 8-bit sum, mod 256, of all payload bytes. The length bytes are excluded.
- IDLE: byte_ready=0, busy=0.
  - start=1 -> LEN_LO.
  - Same edge: clear done, err, word_count, mem_adr, checksum; set busy=1.
- LEN_LO: byte_ready=1; on transfer latch low byte -> LEN_HI.
- LEN_HI: byte_ready=1; on transfer latch high byte.
  - N > 1<<addr_width -> ERR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
- DATA: byte_ready=1.
  - Each transfer shifts the byte into the word assembly register at lane = byte index, and adds it to the checksum.
  - On the BPW-th byte -> WRITE.
- WRITE (exactly one cycle): byte_ready=0, mem_we=1, mem_din=assembled word, mem_adr=current address.
  - Next edge: mem_adr increments (wraps to 0 only after the final word, never used), word_count increments.
  - If word_count (after increment) == N -> CSUM, else -> DATA.
- Latency: last byte of a word accepted at edge t -> mem_we high during cycle t..t+1. Throughput is BPW+1 cycles per word minimum.
- CSUM: byte_ready=1; on transfer compare with the accumulated sum.
  - Equal -> DONE.
  - Else -> ERR.
- DONE: busy=0, done=1 -> IDLE next cycle; done stays high until the next start.
- ERR: busy=0, err=1 -> IDLE next cycle; err stays high until the next start.
  - Words already written are not rolled back.
- start while busy is ignored.
- byte_valid with byte_ready=0 is not consumed; the source must hold the byte.
- mem_we is never asserted outside WRITE.
- mem_din and mem_adr hold their last values between writes.
- Reset mid-load returns to IDLE with all outputs 0 in the same cycle. RAM contents are left as written.
- Exactly one of done/err is set per completed load. Both are 0 while busy.

Test Plan:
1. Good load (addr_width=8, data_width=16): start; bytes 02 00 34 12 CD AB BE with valid held high -> mem_we pulses write 0x1234@0 then 0xABCD@1; done=1, err=0, word_count=2; byte_ready low during each WRITE cycle.
2. Bad checksum: same frame with final byte 0xBF -> both words written, err=1, done=0, busy=0.
3. Zero length: bytes 00 00 00 -> no mem_we, done=1, word_count=0. Overflow: bytes 01 01 (N=257) -> err=1 right after LEN_HI, no writes, byte_ready=0.
4. Backpressure/gaps: frame from test 1 with byte_valid toggled randomly and start pulsed mid-load -> identical writes and done; the mid-load start has no effect.
5. Reset mid-load: assert rst_n=0 after the 3rd byte of test 1 -> all outputs 0 asynchronously. A following full good frame loads 0x1234@0 and 0xABCD@1 with done=1.
6. Full store: N=256 words with data = address, correct checksum -> 256 writes at addresses 0..255, done=1, word_count=256.
